// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and owner tags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_port_arbiter_pkg;

    // Arbitration mode: free arbitration, or port held by a locked DBG burst
    typedef enum logic {
        ST_ARB      = 1'b0,
        ST_DBG_LOCK = 1'b1
    } arb_state_t;

    // Owner tag carried alongside an in-flight load to route its response
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection between CPU and DBG from requests, FSM state, starvation force and last winner.
// Latency: purely combinational, same-cycle grants.
// Backpressure: a requester without a grant must hold its request; at most one grant per cycle.
// Config: DMEM_ARB_RR_EN selects round-robin on contention instead of CPU-first.
module dmem_arb_pick
    import dmem_port_arbiter_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dbg_req,
    input  arb_state_t state,
    input  logic       force_dbg,
`ifdef DMEM_ARB_RR_EN
    input  logic       last,
`endif
    output logic       cpu_gnt,
    output logic       dbg_gnt
);

    logic cpu_first;

    // Decide who wins on contention: fixed CPU priority, or whoever did not win last time
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        cpu_first = (last == OWN_DBG);
`else
        cpu_first = 1'b1;
`endif
    end

    // Grant generation; force_dbg overrides the contention rule, a locked burst excludes the CPU
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        case (state)
            ST_ARB: begin
                cpu_gnt = cpu_req & ~force_dbg & (~dbg_req | cpu_first);
                dbg_gnt = dbg_req & (force_dbg | ~cpu_req | ~cpu_first);
            end
            ST_DBG_LOCK: begin
                dbg_gnt = dbg_req;
            end
            default: begin
                cpu_gnt = 1'b0;
                dbg_gnt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage and a DBG/loader port.
// Latency: grant same cycle, memory request registered next cycle, load data returned 2 cycles after handshake.
// Backpressure: combinational grant; a losing CPU sees cpu_stall, DBG is forced through after MAX_WAIT losses.
// Config: define DMEM_ARB_RR_EN for round-robin contention resolution (default: CPU over DBG).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [WW-1:0] dbg_wait;
    logic          force_dbg;
    logic          cpu_hs;
    logic          dbg_hs;
    logic          pend_vld;
    logic          pend_own;
`ifdef DMEM_ARB_RR_EN
    logic          last;
`endif

    assign force_dbg = (dbg_wait == WAIT_MAX);
    assign cpu_hs    = cpu_req & cpu_gnt;
    assign dbg_hs    = dbg_req & dbg_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    dmem_arb_pick u_pick (
        .cpu_req   (cpu_req),
        .dbg_req   (dbg_req),
        .state     (state),
        .force_dbg (force_dbg),
`ifdef DMEM_ARB_RR_EN
        .last      (last),
`endif
        .cpu_gnt   (cpu_gnt),
        .dbg_gnt   (dbg_gnt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ARB;
        else        state <= state_nxt;
    end

    // Lock is taken and released only by DBG handshakes; an idle DBG keeps the lock
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:      if (dbg_hs &&  dbg_lock) state_nxt = ST_DBG_LOCK;
            ST_DBG_LOCK: if (dbg_hs && !dbg_lock) state_nxt = ST_ARB;
            default:     state_nxt = ST_ARB;
        endcase
    end

    // Count cycles a pending DBG request loses in ARB; saturate, clear when DBG is served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_wait <= '0;
        end else if (dbg_hs) begin
            dbg_wait <= '0;
        end else if ((state == ST_ARB) && dbg_req && !force_dbg) begin
            dbg_wait <= dbg_wait + 1'b1;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember the most recent winner for round-robin contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last <= OWN_CPU;
        else if (cpu_hs) last <= OWN_CPU;
        else if (dbg_hs) last <= OWN_DBG;
    end
`endif

    // Register the winning request onto the memory port; idle cycles drop we but hold addr/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pend_vld  <= 1'b0;
            pend_own  <= OWN_CPU;
        end else begin
            pend_vld <= (cpu_hs & ~cpu_we) | (dbg_hs & ~dbg_we);
            pend_own <= dbg_hs ? OWN_DBG : OWN_CPU;
            if (cpu_hs) begin
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (dbg_hs) begin
                mem_we    <= dbg_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
            end else begin
                mem_we    <= 1'b0;
            end
        end
    end

    // Capture load data and pulse rvalid to the owner; rdata holds between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= pend_vld & (pend_own == OWN_CPU);
            dbg_rvalid <= pend_vld & (pend_own == OWN_DBG);
            if (pend_vld && (pend_own == OWN_CPU)) cpu_rdata <= mem_rdata;
            if (pend_vld && (pend_own == OWN_DBG)) dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a per-cycle reference model.
// Latency: model expects load data two cycles after the handshake.
// Backpressure: requesters hold their request until granted.
module tb_dmem_port_arbiter;

    localparam int MAXW = 8;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // memory behind the port, and the program-order reference image of it
    logic [31:0] phys_mem [64];
    logic [31:0] ref_mem  [64];

    typedef struct {
        logic        own;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t rq[$];

    // model state
    logic        m_lock;
    int          m_wait;
    logic        m_last;
    logic        e_mwe;
    logic [31:0] e_maddr, e_mwd, m_crd, m_drd;

    dmem_port_arbiter #(.DW(32), .AW(32), .MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = phys_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) phys_mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_lock  = 1'b0;
        m_wait  = 0;
        m_last  = 1'b0;
        e_mwe   = 1'b0;
        e_maddr = '0;
        e_mwd   = '0;
        m_crd   = '0;
        m_drd   = '0;
        rq.delete();
    endtask

    // Reference model and per-cycle comparison, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin
        logic e_cg, e_dg, e_cv, e_dv;
        if (!rst_n) model_reset();
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (m_lock || m_wait == MAXW) begin
            e_dg = dbg_req;
        end else if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
            if (m_last) e_cg = 1'b1;
            else        e_dg = 1'b1;
`else
            e_cg = 1'b1;
`endif
        end else begin
            e_cg = cpu_req;
            e_dg = dbg_req;
        end
        e_cv = 1'b0;
        e_dv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc_n) begin
            if (rq[0].own) begin e_dv = 1'b1; m_drd = rq[0].data; end
            else           begin e_cv = 1'b1; m_crd = rq[0].data; end
            void'(rq.pop_front());
        end
        chk("cpu_gnt",    cpu_gnt,    e_cg);
        chk("dbg_gnt",    dbg_gnt,    e_dg);
        chk("cpu_stall",  cpu_stall,  cpu_req & ~e_cg);
        chk("mem_we",     mem_we,     e_mwe);
        chk("mem_addr",   mem_addr,   e_maddr);
        chk("mem_wdata",  mem_wdata,  e_mwd);
        chk("cpu_rvalid", cpu_rvalid, e_cv);
        chk("cpu_rdata",  cpu_rdata,  m_crd);
        chk("dbg_rvalid", dbg_rvalid, e_dv);
        chk("dbg_rdata",  dbg_rdata,  m_drd);
        if (rst_n) begin
            if (e_cg || e_dg) begin
                rsp_t r;
                logic        we;
                logic [31:0] a, d;
                we = e_cg ? cpu_we : dbg_we;
                a  = e_cg ? cpu_addr : dbg_addr;
                d  = e_cg ? cpu_wdata : dbg_wdata;
                e_mwe = we; e_maddr = a; e_mwd = d;
                if (we) begin
                    ref_mem[a[7:2]] = d;
                end else begin
                    r.own = e_dg; r.data = ref_mem[a[7:2]]; r.due = cyc_n + 2;
                    rq.push_back(r);
                end
                m_last = e_dg;
            end else begin
                e_mwe = 1'b0;
            end
            if (e_dg) begin
                m_lock = dbg_lock;
                m_wait = 0;
            end else if (!m_lock && dbg_req && m_wait < MAXW) begin
                m_wait++;
            end
        end
        cyc_n++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = lk;
    endtask

    initial begin
        int first_dbg;
        int k;
        for (int i = 0; i < 64; i++) begin
            phys_mem[i] = 32'h1000_0000 + i;
            ref_mem[i]  = 32'h1000_0000 + i;
        end
        phys_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        model_reset();
        cyc();
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: CPU load of word 4
        set_cpu(1, 0, 32'h10, 0);
        @(negedge clk);
        chk("t1_gnt", cpu_gnt, 1);
        cyc();
        set_cpu(0, 0, 32'h10, 0);
        cyc();
        @(negedge clk);
        chk("t1_rvalid", cpu_rvalid, 1);
        chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cyc();

        // 2: store then immediate load of the same address
        set_cpu(1, 1, 32'h20, 32'hAA);
        cyc();
        set_cpu(1, 0, 32'h20, 0);
        @(negedge clk);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 32'h20);
        cyc();
        set_cpu(0, 0, 32'h20, 0);
        @(negedge clk);
        chk("t2_we_off", mem_we, 0);
        cyc();
        @(negedge clk);
        chk("t2_rvalid", cpu_rvalid, 1);
        chk("t2_rdata", cpu_rdata, 32'hAA);
        cyc();
        cyc();

`ifdef DMEM_ARB_RR_EN
        // 5: round-robin alternation after a DBG-only store
        set_dbg(1, 1, 32'h3C, 32'h55, 0);
        cyc();
        set_dbg(1, 0, 32'h3C, 0, 0);
        k = 0;
        set_cpu(1, 0, 32'h40, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_cpu_gnt", cpu_gnt, (i % 2 == 0));
            chk("t5_dbg_gnt", dbg_gnt, (i % 2 == 1));
            if (cpu_gnt) k++;
            cyc();
            cpu_addr = 32'h40 + 4 * k;
        end
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        repeat (3) cyc();
`else
        // 3: starvation guard under fixed priority
        set_cpu(1, 0, 32'h04, 0);
        set_dbg(1, 0, 32'h08, 0, 0);
        first_dbg = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbg_gnt && first_dbg < 0) first_dbg = i;
            if (i == 9) chk("t3_cpu_after", cpu_gnt, 1);
            cyc();
        end
        chk("t3_first_dbg", first_dbg, 8);
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        repeat (3) cyc();
`endif

        // 4: locked DBG burst while the CPU waits
        set_dbg(1, 0, 32'h08, 0, 1);
        cyc();
        set_cpu(1, 0, 32'h34, 0);
        set_dbg(1, 1, 32'h30, 32'h1, 1);
        @(negedge clk);
        chk("t4_stall_a", cpu_stall, 1);
        cyc();
        set_dbg(0, 0, 32'h30, 0, 0);
        @(negedge clk);
        chk("t4_stall_gap", cpu_stall, 1);
        cyc();
        set_dbg(1, 1, 32'h34, 32'h2, 1);
        @(negedge clk);
        chk("t4_stall_b", cpu_stall, 1);
        cyc();
        set_dbg(1, 1, 32'h38, 32'h3, 0);
        @(negedge clk);
        chk("t4_stall_c", cpu_stall, 1);
        cyc();
        set_dbg(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_cpu_gnt", cpu_gnt, 1);
        cyc();
        set_cpu(0, 0, 0, 0);
        cyc();
        @(negedge clk);
        chk("t4_readback", cpu_rdata, 32'h2);
        cyc();

        // 6: reset pulse while a CPU load is in flight
        set_cpu(1, 0, 32'h10, 0);
        cyc();
        set_cpu(0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_rdata", cpu_rdata, 0);
        chk("t6_rst_rvalid", cpu_rvalid, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_rvalid", cpu_rvalid, 0);
            cyc();
        end
        set_cpu(1, 0, 32'h10, 0);
        cyc();
        set_cpu(0, 0, 0, 0);
        cyc();
        @(negedge clk);
        chk("t6_resume_rvalid", cpu_rvalid, 1);
        chk("t6_resume_rdata", cpu_rdata, 32'hDEAD_BEEF);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
